// File: rtl/fifo_chain_checker.sv
// Drains the ECC FIFO chain and checks each word against an incrementing pattern.
// Counters reflect a word two cycles after its read; ECC flags one cycle after sampling; reads only when enabled and non-empty.
module fifo_chain_checker #(
  parameter int N         = 32,
  parameter int K         = 48,
  parameter int CNT_W     = 32,
  parameter int LOCK_LOSS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [N-1:0]     fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_o,
  input  logic [K-1:0]     sbiterr_i,
  input  logic [K-1:0]     dbiterr_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [CNT_W-1:0] bitflip_cnt_o,
  output logic [CNT_W-1:0] resync_cnt_o,
  output logic [CNT_W-1:0] sbit_cnt_o,
  output logic [CNT_W-1:0] dbit_cnt_o,
  output logic [N-1:0]     first_err_data_o,
  output logic [N-1:0]     first_err_exp_o
);

  localparam int PW = $clog2(((N > K) ? N : K) + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam int RW = $clog2(LOCK_LOSS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t        state;
  logic          word_vld;
  logic [N-1:0]  expected;
  logic [RW-1:0] run_cnt;
  logic          err_captured;

  logic          sync_word;
  logic          check_word;
  logic          mismatch;
  logic          lock_lost;
  logic [RW-1:0] run_next;
  logic [PW-1:0] flip_bits;
  logic [PW-1:0] sbit_bits;
  logic [PW-1:0] dbit_bits;

  // Sum is formed one bit wider than either operand so overflow is visible.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign fifo_rd_o = enable_i & ~fifo_empty_i & (state != IDLE);

  always_comb begin
    sync_word  = word_vld && (state == SYNC);
    check_word = word_vld && (state == CHECK);
    mismatch   = check_word && (fifo_data_i != expected);
    run_next   = run_cnt;
    if (check_word) run_next = mismatch ? run_cnt + RW'(1) : '0;
    lock_lost  = mismatch && (run_next == RW'(LOCK_LOSS));
    flip_bits  = PW'($countones(fifo_data_i ^ expected));
    sbit_bits  = PW'($countones(sbiterr_i));
    dbit_bits  = PW'($countones(dbiterr_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      word_vld         <= 1'b0;
      expected         <= '0;
      run_cnt          <= '0;
      err_captured     <= 1'b0;
      locked_o         <= 1'b0;
      word_cnt_o       <= '0;
      mismatch_cnt_o   <= '0;
      bitflip_cnt_o    <= '0;
      resync_cnt_o     <= '0;
      sbit_cnt_o       <= '0;
      dbit_cnt_o       <= '0;
      first_err_data_o <= '0;
      first_err_exp_o  <= '0;
    end else begin
      word_vld <= fifo_rd_o;

      if (!enable_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= SYNC;
          SYNC:    if (sync_word) state <= CHECK;
          CHECK:   if (lock_lost) state <= SYNC;
          default: state <= IDLE;
        endcase
      end

      // Expected advances on every checked word, match or not, so isolated upsets keep lock.
      if (sync_word) begin
        expected <= fifo_data_i + N'(1);
        locked_o <= 1'b1;
      end else if (check_word) begin
        expected <= expected + N'(1);
      end
      if (lock_lost) locked_o <= 1'b0;

      if (clear_i) begin
        run_cnt          <= '0;
        err_captured     <= 1'b0;
        word_cnt_o       <= '0;
        mismatch_cnt_o   <= '0;
        bitflip_cnt_o    <= '0;
        resync_cnt_o     <= '0;
        sbit_cnt_o       <= '0;
        dbit_cnt_o       <= '0;
        first_err_data_o <= '0;
        first_err_exp_o  <= '0;
      end else begin
        run_cnt    <= lock_lost ? '0 : run_next;
        sbit_cnt_o <= sat_add(sbit_cnt_o, sbit_bits);
        dbit_cnt_o <= sat_add(dbit_cnt_o, dbit_bits);
        if (word_vld) word_cnt_o <= sat_add(word_cnt_o, PW'(1));
        if (mismatch) begin
          mismatch_cnt_o <= sat_add(mismatch_cnt_o, PW'(1));
          bitflip_cnt_o  <= sat_add(bitflip_cnt_o, flip_bits);
          if (!err_captured) begin
            err_captured     <= 1'b1;
            first_err_data_o <= fifo_data_i;
            first_err_exp_o  <= expected;
          end
        end
        if (lock_lost) resync_cnt_o <= sat_add(resync_cnt_o, PW'(1));
      end
    end
  end

endmodule

// File: tb/tb_fifo_chain_checker.sv
// Bench: drives a behavioural FIFO chain into two checkers (32-bit and 4-bit counters)
// and compares both against a transaction-level model every cycle.
module tb_fifo_chain_checker;

  localparam int LL = 8;

  logic        clk_i        = 1'b0;
  logic        rst_i        = 1'b1;
  logic        enable_i     = 1'b0;
  logic        clear_i      = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic [31:0] fifo_data_i  = '0;
  logic [47:0] sbiterr_i    = '0;
  logic [47:0] dbiterr_i    = '0;

  logic        fifo_rd_o, locked_o;
  logic [31:0] word_cnt_o, mismatch_cnt_o, bitflip_cnt_o, resync_cnt_o, sbit_cnt_o, dbit_cnt_o;
  logic [31:0] first_err_data_o, first_err_exp_o;

  logic        s_rd, s_locked;
  logic [3:0]  s_word, s_mis, s_flip, s_res, s_sb, s_db;
  logic [31:0] s_fed, s_fee;

  always #5 clk_i = ~clk_i;

  fifo_chain_checker #(.N(32), .K(48), .CNT_W(32), .LOCK_LOSS(LL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
    .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i), .locked_o(locked_o),
    .word_cnt_o(word_cnt_o), .mismatch_cnt_o(mismatch_cnt_o), .bitflip_cnt_o(bitflip_cnt_o),
    .resync_cnt_o(resync_cnt_o), .sbit_cnt_o(sbit_cnt_o), .dbit_cnt_o(dbit_cnt_o),
    .first_err_data_o(first_err_data_o), .first_err_exp_o(first_err_exp_o)
  );

  fifo_chain_checker #(.N(32), .K(48), .CNT_W(4), .LOCK_LOSS(LL)) dut_small (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(s_rd),
    .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i), .locked_o(s_locked),
    .word_cnt_o(s_word), .mismatch_cnt_o(s_mis), .bitflip_cnt_o(s_flip),
    .resync_cnt_o(s_res), .sbit_cnt_o(s_sb), .dbit_cnt_o(s_db),
    .first_err_data_o(s_fed), .first_err_exp_o(s_fee)
  );

  // Model: true (unbounded) event counts; a saturating counter must read min(count, 2^W-1).
  int          m_mode = 0;   // 0 idle, 1 hunting for pattern, 2 tracking
  bit          m_vld = 0, m_locked = 0, m_cap = 0;
  logic [31:0] m_exp = '0, m_fed = '0, m_fee = '0;
  int          m_run = 0;
  longint      c_word = 0, c_mis = 0, c_flip = 0, c_res = 0, c_sb = 0, c_db = 0;

  always @(posedge clk_i or posedge rst_i) begin
    bit rd_now, lost, hunted;
    if (rst_i) begin
      m_mode = 0; m_vld = 0; m_locked = 0; m_cap = 0; m_exp = '0; m_fed = '0; m_fee = '0;
      m_run = 0; c_word = 0; c_mis = 0; c_flip = 0; c_res = 0; c_sb = 0; c_db = 0;
    end else begin
      rd_now = enable_i && !fifo_empty_i && (m_mode != 0);
      lost   = 0;
      hunted = m_vld && (m_mode == 1);
      if (m_vld) begin
        c_word++;
        if (m_mode == 1) begin
          m_exp = fifo_data_i + 32'd1;
          m_locked = 1;
        end else begin
          if (fifo_data_i == m_exp) m_run = 0;
          else begin
            c_mis++;
            c_flip += $countones(fifo_data_i ^ m_exp);
            if (!m_cap) begin m_cap = 1; m_fed = fifo_data_i; m_fee = m_exp; end
            m_run++;
          end
          m_exp = m_exp + 32'd1;
          if (m_run == LL) begin c_res++; m_locked = 0; m_run = 0; lost = 1; end
        end
      end
      c_sb += $countones(sbiterr_i);
      c_db += $countones(dbiterr_i);
      if (clear_i) begin
        c_word = 0; c_mis = 0; c_flip = 0; c_res = 0; c_sb = 0; c_db = 0;
        m_run = 0; m_cap = 0; m_fed = '0; m_fee = '0;
      end
      if (!enable_i) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (hunted) m_mode = 2;
      else if (lost) m_mode = 1;
      m_vld = rd_now;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint cap(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check_outputs();
    chk("locked",        64'(locked_o),         64'(m_locked));
    chk("word_cnt",      64'(word_cnt_o),       cap(c_word, 32));
    chk("mismatch_cnt",  64'(mismatch_cnt_o),   cap(c_mis, 32));
    chk("bitflip_cnt",   64'(bitflip_cnt_o),    cap(c_flip, 32));
    chk("resync_cnt",    64'(resync_cnt_o),     cap(c_res, 32));
    chk("sbit_cnt",      64'(sbit_cnt_o),       cap(c_sb, 32));
    chk("dbit_cnt",      64'(dbit_cnt_o),       cap(c_db, 32));
    chk("first_err_dat", 64'(first_err_data_o), 64'(m_fed));
    chk("first_err_exp", 64'(first_err_exp_o),  64'(m_fee));
    chk("s_locked",      64'(s_locked),         64'(m_locked));
    chk("s_word_cnt",    64'(s_word),           cap(c_word, 4));
    chk("s_mismatch",    64'(s_mis),            cap(c_mis, 4));
    chk("s_bitflip",     64'(s_flip),           cap(c_flip, 4));
    chk("s_resync",      64'(s_res),            cap(c_res, 4));
    chk("s_sbit",        64'(s_sb),             cap(c_sb, 4));
    chk("s_dbit",        64'(s_db),             cap(c_db, 4));
    chk("s_first_dat",   64'(s_fed),            64'(m_fed));
    chk("s_first_exp",   64'(s_fee),            64'(m_fee));
  endtask

  // Chain source: a queue of words; data appears the cycle after the DUT reads.
  logic [31:0] q[$];
  bit          prev_rd = 0;
  int          reads = 0;
  bit          nx_en = 0, nx_empty = 0, nx_clear = 0;
  logic [47:0] nx_sb = '0, nx_db = '0;

  task automatic step();
    bit exp_rd;
    @(negedge clk_i);
    check_outputs();
    if (prev_rd && q.size() != 0) fifo_data_i = q.pop_front();
    else fifo_data_i = $urandom;
    enable_i     = nx_en;
    clear_i      = nx_clear;
    nx_clear     = 0;
    sbiterr_i    = nx_sb;
    dbiterr_i    = nx_db;
    fifo_empty_i = nx_empty || (q.size() == 0);
    #1;
    exp_rd = enable_i && !fifo_empty_i && (m_mode != 0);
    chk("fifo_rd", 64'(fifo_rd_o), 64'(exp_rd));
    chk("s_fifo_rd", 64'(s_rd), 64'(exp_rd));
    prev_rd = fifo_rd_o;
    if (fifo_rd_o) reads++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || prev_rd) && n < budget) begin step(); n++; end
    chk("drain_done", 64'(q.size() != 0 || prev_rd), 64'(0));
    step(); step();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    prev_rd = 0;
    #1;
    check_outputs();
    chk("rd_in_reset", 64'(fifo_rd_o), 64'(0));
    chk("word_in_reset", 64'(word_cnt_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [31:0] gen = 32'h1000;

  task automatic feed();
    logic [31:0] v;
    int r;
    while (q.size() < 4) begin
      r = $urandom_range(0, 63);
      if (r == 3) gen = $urandom;
      v = gen;
      if (r < 3) v = v ^ (32'd1 << $urandom_range(0, 31));
      q.push_back(v);
      gen = gen + 32'd1;
    end
  endtask

  task automatic random_ecc();
    logic [63:0] t;
    t = {$urandom, $urandom};
    nx_sb = ($urandom_range(0, 3) == 0) ? t[47:0] : '0;
    t = {$urandom, $urandom};
    nx_db = ($urandom_range(0, 7) == 0) ? t[47:0] : '0;
  endtask

  initial begin
    logic [31:0] r;
    longint      flip_exp;

    step(); step();
    chk("rst_word_cnt", 64'(word_cnt_o), 64'(0));
    chk("rst_locked", 64'(locked_o), 64'(0));
    chk("rst_rd", 64'(fifo_rd_o), 64'(0));
    rst_i = 1'b0;

    // Clean incrementing stream.
    for (int i = 'h100; i <= 'h1FF; i++) q.push_back(32'(i));
    nx_en = 1;
    drain(600);
    chk("p1_word_cnt", 64'(word_cnt_o), 64'd256);
    chk("p1_mismatch", 64'(mismatch_cnt_o), 64'd0);
    chk("p1_bitflip", 64'(bitflip_cnt_o), 64'd0);
    chk("p1_locked", 64'(locked_o), 64'd1);

    // Pattern wrap after relock on 0xFFFFFFFD.
    nx_en = 0;
    repeat (3) step();
    q.push_back(32'hFFFF_FFFD); q.push_back(32'hFFFF_FFFE); q.push_back(32'hFFFF_FFFF);
    q.push_back(32'h0); q.push_back(32'h1);
    nx_en = 1;
    drain(50);
    chk("wrap_word_cnt", 64'(word_cnt_o), 64'd261);
    chk("wrap_mismatch", 64'(mismatch_cnt_o), 64'd0);

    // Single corrupted word, then 8 bad words forcing resync, then relock.
    nx_en = 0; nx_clear = 1;
    repeat (3) step();
    for (int i = 'h100; i <= 'h10F; i++) q.push_back((i == 'h105) ? 32'h0001_0104 : 32'(i));
    flip_exp = 2;
    for (int i = 0; i < 8; i++) begin
      r = $urandom | 32'h8000_0000;
      flip_exp += $countones(r ^ (32'h110 + 32'(i)));
      q.push_back(r);
    end
    q.push_back(32'h500); q.push_back(32'h501);
    nx_en = 1;
    drain(100);
    chk("err_word_cnt", 64'(word_cnt_o), 64'd26);
    chk("err_mismatch", 64'(mismatch_cnt_o), 64'd9);
    chk("err_bitflip", 64'(bitflip_cnt_o), 64'(flip_exp));
    chk("err_first_dat", 64'(first_err_data_o), 64'h0001_0104);
    chk("err_first_exp", 64'(first_err_exp_o), 64'h105);
    chk("err_resync", 64'(resync_cnt_o), 64'd1);
    chk("err_relocked", 64'(locked_o), 64'd1);

    // ECC flag counting and saturation of the narrow counters.
    nx_en = 0; nx_clear = 1;
    step(); step();
    nx_sb = 48'h7; step();
    nx_sb = '0; nx_db = 48'h8000_0000_0000; step(); step();
    nx_db = '0; step();
    chk("ecc_sbit", 64'(sbit_cnt_o), 64'd3);
    chk("ecc_dbit", 64'(dbit_cnt_o), 64'd2);
    nx_sb = 48'h1;
    repeat (20) step();
    nx_sb = '0; step();
    chk("sat_small_sbit", 64'(s_sb), 64'd15);
    chk("sat_big_sbit", 64'(sbit_cnt_o), 64'd23);
    nx_clear = 1; step(); step();
    chk("clr_word", 64'(word_cnt_o), 64'd0);
    chk("clr_mismatch", 64'(mismatch_cnt_o), 64'd0);
    chk("clr_bitflip", 64'(bitflip_cnt_o), 64'd0);
    chk("clr_resync", 64'(resync_cnt_o), 64'd0);
    chk("clr_sbit", 64'(sbit_cnt_o), 64'd0);
    chk("clr_dbit", 64'(dbit_cnt_o), 64'd0);
    chk("clr_small_sbit", 64'(s_sb), 64'd0);
    chk("clr_first_dat", 64'(first_err_data_o), 64'd0);

    // Random empty/enable traffic; every issued read must be counted.
    reads = 0; nx_clear = 1;
    for (int i = 0; i < 1500; i++) begin
      feed();
      nx_en    = ($urandom_range(0, 15) != 0);
      nx_empty = ($urandom_range(0, 2) == 0);
      random_ecc();
      step();
    end
    nx_en = 0; nx_sb = '0; nx_db = '0;
    repeat (3) step();
    chk("reads_vs_word_cnt", 64'(word_cnt_o), 64'(reads));

    // Random traffic with clears and a mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      feed();
      nx_en    = ($urandom_range(0, 15) != 0);
      nx_empty = ($urandom_range(0, 2) == 0);
      nx_clear = ($urandom_range(0, 49) == 0);
      random_ecc();
      step();
    end
    nx_en = 0; nx_sb = '0; nx_db = '0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_chain_checker.md
# fifo_chain_checker

Read-side checker for the radiation-test ECC FIFO chain. Drains the chain output port whenever enabled and data is present, compares every word against an expected incrementing pattern, and counts words, mismatching words, flipped bits, loss-of-lock events and ECC single/double-bit error flags from all chain stages. All results are held in saturating counters that slow control reads.

## Interface
Parameters:
- N, 32, data word width
- K, 48, number of FIFO stages, i.e. width of the ECC flag vectors
- CNT_W, 32, width of every statistics counter
- LOCK_LOSS, 8, consecutive mismatching words that force resynchronisation

Ports:
- clk_i  in  1  single clock; all logic on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  level; permits reading the chain
- clear_i  in  1  synchronous one-cycle pulse; zeroes statistics
- fifo_data_i  in  N  chain output data, standard read mode, valid the cycle after a read
- fifo_empty_i  in  1  chain output empty
- fifo_rd_o  out  1  read strobe to the chain output
- sbiterr_i  in  K  per-stage single-bit ECC error flags
- dbiterr_i  in  K  per-stage double-bit ECC error flags
- locked_o  out  1  checker is tracking the pattern
- word_cnt_o  out  CNT_W  words checked
- mismatch_cnt_o  out  CNT_W  words not equal to the expected value
- bitflip_cnt_o  out  CNT_W  sum of popcount(data XOR expected)
- resync_cnt_o  out  CNT_W  lock-loss events
- sbit_cnt_o  out  CNT_W  sum of popcount(sbiterr_i) over all cycles
- dbit_cnt_o  out  CNT_W  sum of popcount(dbiterr_i) over all cycles
- first_err_data_o  out  N  data of the first mismatching word since reset or clear
- first_err_exp_o  out  N  expected value at that first mismatch

## Operation
- Reset value of every output and register: 0; state IDLE.
- States:
  - IDLE: no reads. Go to SYNC when enable_i=1.
  - SYNC: on the first checked word, load expected = data+1, set locked_o, and go to CHECK. That word counts in word_cnt_o only.
  - CHECK: each checked word increments word_cnt_o.
    - If data == expected: clear the run counter.
    - Otherwise: increment mismatch_cnt_o, add popcount(data^expected) to bitflip_cnt_o, and capture first_err_* if none has been captured yet. Increment the run counter.
    - In both cases the next expected value is expected+1 (mod 2^N), so a single corrupted word does not break lock.
    - When the run counter reaches LOCK_LOSS: increment resync_cnt_o, clear locked_o, clear the run counter, and go to SYNC.
- Any state with enable_i=0: go to IDLE. Statistics and the expected value are retained. On re-enable, go to SYNC.
- fifo_rd_o = enable_i & ~fifo_empty_i & (state != IDLE). It is combinational and never asserted while empty.
- The word-valid flag is fifo_rd_o registered once. A read issued in the cycle enable_i falls is still checked.
- ECC counters are independent of state and enable. Every cycle, each counter adds the popcount of its own K-bit vector.
- All counters saturate at 2^CNT_W-1; saturation never wraps to 0.
- Pattern wrap: expected all-ones followed by data 0 is a match.
- clear_i zeroes all six counters, the run counter and first_err_*, and re-arms first-error capture.
  - It does not change state, locked_o or expected.
  - If clear_i coincides with a counted event, the clear wins and that event is dropped.
- rst_i asserted mid-stream: all outputs go to 0 immediately. An in-flight word is discarded.

## Timing
- fifo_rd_o high in cycle t; fifo_data_i sampled in cycle t+1; counters, locked_o and first_err_* show that word from cycle t+2.
- Sustained throughput: 1 word per cycle while the chain is non-empty.
- ECC flags sampled in cycle t are visible in sbit_cnt_o/dbit_cnt_o from cycle t+1.
- Mismatch to resync: the LOCK_LOSS-th consecutive mismatching word drops locked_o in the same cycle its counts appear. The next word read relocks.

## Test plan
- Reset, enable, chain supplies 0x100..0x1FF -> word_cnt=256, mismatch=0, bitflip=0, locked_o=1 from the first word.
- Stream continues 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 after a locked 0xFFFFFFFD -> no mismatches (wrap check).
- In a locked stream at 0x100.., word 0x105 replaced by 0x00010104 -> mismatch=1, bitflip=2, first_err_data=0x00010104, first_err_exp=0x105; 0x106 matches; locked_o stays 1.
- 8 consecutive random words -> resync=1, locked_o=0 at the 8th; next word 0x500 relocks, then 0x501 matches.
- sbiterr_i=0x7 for 1 cycle and dbiterr_i=0x800000000000 for 2 cycles -> sbit_cnt=3, dbit_cnt=2. With CNT_W=4, 20 single flags -> sbit_cnt=15. clear_i -> all counters 0 the next cycle.
- fifo_empty_i toggled randomly and enable_i dropped mid-stream -> fifo_rd_o never high while empty or disabled; word_cnt equals the number of reads issued, including the last in-flight read.
